result_store: RTL and testbench
===============================

Name: result_store

Overview:
- Capture end of the operand-feed path: the ALU result is written into a DEPTH-entry result memory each time the store strobe rises.
- The store strobe is a level signal from the sequencer; the block detects its rising edge and writes one cycle later, using the same timing as the operand feeder.
- A registered read port lets the top level or the bench read back stored results; status outputs report progress.

Parameters:
- DATA_W, 32, result word width (IEEE-754 single).
- DEPTH, 16, number of result entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- storeData  input  1  level strobe; each rising edge requests one store.
- result  input  DATA_W  ALU result, sampled on the write cycle.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  registered read data, mem[rd_addr] one cycle later.
- wr_index  output  ADDR_W  next entry to be written.
- count  output  ADDR_W+1  stores completed, saturating at DEPTH.
- done  output  1  one-cycle pulse on each write cycle.
- wrapped  output  1  sticky; set when wr_index wraps from DEPTH-1 to 0.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rd_data=0, wr_index=0, count=0, done=0, wrapped=0.
  - Internal storeData_prev=0, store_pending=0.
  - Memory contents are not reset.
- Edge detect, every clk: edge = storeData & ~storeData_prev. storeData_prev <= storeData.
- Cycle N, edge=1: store_pending <= 1.
- Cycle N+1, store_pending=1:
  - mem[wr_index] <= result (value present at that edge).
  - wr_index <= wr_index+1, modulo DEPTH.
  - count <= min(count+1, DEPTH).
  - done=1 for exactly this cycle.
  - store_pending <= 0, unless edge=1 in the same cycle, in which case pending stays 1.
- Latency: edge cycle to memory write is 1 cycle; write to readable via rd_data is 1 further cycle.
- Wrap: the write at index DEPTH-1 sets wrapped=1. Later writes overwrite oldest entries. count stays at DEPTH.
- Read vs write:
  - rd_data <= mem[rd_addr] every cycle.
  - Same-cycle read and write to the same address returns the old data (read-before-write).
- storeData held high: exactly one store; a new store needs a low then a high.
- Reset mid-operation: a pending store is discarded and no write occurs. Status returns to reset values. Stored memory is untouched but is treated as stale.
- No backpressure: the strobe source guarantees at least 2 cycles between rising edges.

Optional Feature:
- Macro: RESULT_CHECK_EN.
- Defined:
  - Adds an internal expected-result ROM (DEPTH x DATA_W, initialised from a constant table).
  - Adds outputs mismatch_cnt (ADDR_W+1, saturating) and mismatch (1, sticky).
  - On each write cycle, result is compared with expected[wr_index]. On inequality, mismatch_cnt increments and mismatch is set.
  - Both reset to 0.
- Undefined: no ROM, no comparator, no extra ports. Behaviour is otherwise identical.

Decomposition:
- Package alu_io_pkg:
  - DATA_W, DEPTH, ADDR_W constants.
  - Expected-result constant table, shared with the operand feeder's operand table.
- Sub-module rise_detect:
  - Registered rising-edge-to-pending pulse with async active-low reset.
  - Reusable by the operand feeder.

Test Plan:
- Reset then idle 10 cycles -> wr_index=0, count=0, done=0, wrapped=0, rd_data=0.
- result=0x40224dd3, storeData rises at cycle 5 and held high 8 cycles -> done only at cycle 6, single write. rd_addr=0 gives rd_data=0x40224dd3 one cycle later. count=1.
- 17 strobes with result=0x3f800000+i -> wrapped=1 after strobe 16, count=16, wr_index=1. mem[0]=0x3f800010.
- rst_n low in the cycle after an edge (store pending) -> no write, done stays 0, wr_index=0. mem[0] retains its prior value.
- Same-cycle write and read at address 3 -> rd_data shows the old value. Next read shows the new value.
- RESULT_CHECK_EN with expected[0]=0x40224dd3: store 0x40224dd3, then store a mismatched 0x00000000 at index 1 -> mismatch_cnt=1, mismatch=1. Without the macro, the ports are absent and the design elaborates cleanly.

Source files
------------

// File: rtl/alu_io_pkg.sv
// Shared constants for the ALU operand/result path: word width, result memory
// geometry, the expected-result table and the status register layout.
package alu_io_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    // Expected ALU results, one per result entry. The operand feeder's
    // operand table is built from the same index order.
    localparam logic [DATA_W-1:0] EXPECTED [DEPTH] = '{
        32'h40224dd3, 32'h3f800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40a00000, 32'h40c00000, 32'h40e00000,
        32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
        32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
    };

    // Progress status of the result memory.
    typedef struct packed {
        logic [ADDR_W-1:0] wr_index;
        logic [ADDR_W:0]   count;
        logic              wrapped;
    } status_t;

    // Increment that holds at the given limit.
    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] value,
                                                input logic [ADDR_W:0] limit);
        return (value == limit) ? value : value + (ADDR_W + 1)'(1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level strobe: a rise seen in one cycle becomes a
// one-cycle registered pending pulse in the next cycle. Reused by the operand
// feeder so both paths share the same strobe-to-action timing.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pending_o
);

    logic prev_q;
    logic pending_q;
    logic rise;

    assign rise = level_i & ~prev_q;

    // Remember the previous strobe level and register a rise as pending.
    // A rise in the pending cycle simply keeps pending high for one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, no
            // matter the order of statements or always blocks.
            prev_q    <= level_i;
            pending_q <= rise;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/result_store.sv
// Result capture memory: writes the ALU result into a DEPTH-entry memory one
// cycle after each rising edge of storeData, offers a registered read port and
// reports write progress. Optional feature macro: RESULT_CHECK_EN adds a
// comparison of each stored result against the expected-result table.
module result_store
    import alu_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              storeData,
    input  logic [DATA_W-1:0] result,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_index,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              wrapped
`ifdef RESULT_CHECK_EN
    ,
    output logic [ADDR_W:0]   mismatch_cnt,
    output logic              mismatch
`endif
);

    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic              store_pending;
    status_t           status_q;
    status_t           status_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    rise_detect u_rise_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_i   (storeData),
        .pending_o (store_pending)
    );

    // Next status: advance index, saturate count and latch wrap on each write.
    always_comb begin
        // NOTE: default first so every path assigns status_d and no latch forms.
        status_d = status_q;
        if (store_pending) begin
            status_d.wr_index = status_q.wr_index + ADDR_W'(1);
            status_d.count    = sat_inc(status_q.count, COUNT_MAX);
            if (status_q.wr_index == LAST_IDX) begin
                status_d.wrapped = 1'b1;
            end
        end
    end

    // Status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // Result memory write port.
    // NOTE: no reset on the storage array; it keeps stale contents across reset
    // and maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (store_pending) begin
            mem_q[status_q.wr_index] <= result;
        end
    end

    // Registered read port; a same-edge write to the same address shows old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

`ifdef RESULT_CHECK_EN
    logic [ADDR_W:0] mismatch_cnt_q;
    logic            mismatch_q;

    // Compare each stored word with the expected table entry at its index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt_q <= '0;
            mismatch_q     <= 1'b0;
        end else if (store_pending && (result != EXPECTED[status_q.wr_index])) begin
            mismatch_cnt_q <= sat_inc(mismatch_cnt_q, '1);
            mismatch_q     <= 1'b1;
        end
    end

    assign mismatch_cnt = mismatch_cnt_q;
    assign mismatch     = mismatch_q;
`endif

    assign rd_data  = rd_data_q;
    assign wr_index = status_q.wr_index;
    assign count    = status_q.count;
    assign wrapped  = status_q.wrapped;
    assign done     = store_pending;

endmodule

// File: tb/tb_result_store.sv
// Self-checking bench for result_store: a cycle-level reference model of the
// result memory and status is compared with the DUT on every falling edge,
// and directed scenarios add hand-computed expectations.
module tb_result_store;
    import alu_io_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              storeData = 1'b0;
    logic [DATA_W-1:0] result = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_index;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              wrapped;
`ifdef RESULT_CHECK_EN
    logic [ADDR_W:0]   mismatch_cnt;
    logic              mismatch;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    result_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .storeData (storeData),
        .result    (result),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_index  (wr_index),
        .count     (count),
        .done      (done),
        .wrapped   (wrapped)
`ifdef RESULT_CHECK_EN
        ,
        .mismatch_cnt (mismatch_cnt),
        .mismatch     (mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_wr = 0;
    int          m_count = 0;
    bit          m_wrapped = 0;
    bit          m_store_now = 0;   // a store lands at the end of this cycle
    bit          m_prev = 0;
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 1;
    int          m_mm_cnt = 0;
    bit          m_mm = 0;

    task automatic model_reset();
        m_wr = 0; m_count = 0; m_wrapped = 0;
        m_store_now = 0; m_prev = 0;
        m_rd = '0; m_rd_known = 1;
        m_mm_cnt = 0; m_mm = 0;
    endtask

    task automatic model_step();
        m_rd       = m_mem[rd_addr];
        m_rd_known = m_known[rd_addr];
        if (m_store_now) begin
            if (result != EXPECTED[m_wr]) begin
                m_mm_cnt = (m_mm_cnt < 31) ? m_mm_cnt + 1 : 31;
                m_mm = 1;
            end
            m_mem[m_wr]   = result;
            m_known[m_wr] = 1;
            if (m_wr == DEPTH - 1) m_wrapped = 1;
            m_wr    = (m_wr + 1) % DEPTH;
            m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
        end
        m_store_now = storeData && !m_prev;
        m_prev      = storeData;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare DUT with model on every falling edge.
    always @(negedge clk) begin
        check("wr_index", 32'(wr_index), 32'(m_wr));
        check("count",    32'(count),    32'(m_count));
        check("done",     32'(done),     32'(m_store_now));
        check("wrapped",  32'(wrapped),  32'(m_wrapped));
        if (m_rd_known) check("rd_data", rd_data, m_rd);
`ifdef RESULT_CHECK_EN
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mm_cnt));
        check("mismatch",     32'(mismatch),     32'(m_mm));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        storeData = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_store(input logic [31:0] val);
        result = val;
        storeData = 1'b1;
        tick(1);
        storeData = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_hits;
        bit first_done;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

        // Reset values, checked while reset is held.
        #2;
        check("rst_rd_data",  rd_data,           32'h0);
        check("rst_wr_index", 32'(wr_index),     32'h0);
        check("rst_count",    32'(count),        32'h0);
        check("rst_done",     32'(done),         32'h0);
        check("rst_wrapped",  32'(wrapped),      32'h0);
        #10;
        rst_n = 1'b1;
        tick(10);
        check("idle_wr_index", 32'(wr_index), 32'h0);
        check("idle_count",    32'(count),    32'h0);
        check("idle_done",     32'(done),     32'h0);
        check("idle_wrapped",  32'(wrapped),  32'h0);

        // Strobe held high for 8 cycles: exactly one store.
        result = 32'h40224dd3;
        storeData = 1'b1;
        done_hits = 0;
        first_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 0) first_done = done;
            if (done) done_hits++;
        end
        storeData = 1'b0;
        check("held_first_done", 32'(first_done), 32'h1);
        check("held_done_hits",  32'(done_hits),  32'h1);
        rd_addr = '0;
        tick(1);
        check("held_rd0",   rd_data,       32'h40224dd3);
        check("held_count", 32'(count),    32'h1);

        // 17 stores from a fresh reset: wrap and overwrite of entry 0.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pulse_store(32'h3f800000 + 32'(i));
            if (i == 14) check("wrap_before", 32'(wrapped), 32'h0);
            if (i == 15) begin
                check("wrap_after",    32'(wrapped),  32'h1);
                check("wrap_count16",  32'(count),    32'd16);
                check("wrap_index0",   32'(wr_index), 32'h0);
            end
        end
        check("wrap17_count", 32'(count),    32'd16);
        check("wrap17_index", 32'(wr_index), 32'h1);
        check("wrap17_flag",  32'(wrapped),  32'h1);
        rd_addr = 4'd0;
        tick(1);
        check("wrap_mem0", rd_data, 32'h3f800010);
        rd_addr = 4'd5;
        tick(1);
        check("wrap_mem5", rd_data, 32'h3f800005);

        // Reset while a store is pending: no write happens.
        result = 32'hdeadbeef;
        storeData = 1'b1;
        tick(1);
        rst_n = 1'b0;
        storeData = 1'b0;
        #1;
        check("rstpend_done",  32'(done),     32'h0);
        check("rstpend_index", 32'(wr_index), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rstpend_done2",  32'(done),     32'h0);
        check("rstpend_count",  32'(count),    32'h0);
        rd_addr = 4'd0;
        tick(1);
        check("rstpend_mem0", rd_data, 32'h3f800010);

        // Same-edge write and read at address 3.
        for (int i = 0; i < 3; i++) pulse_store(32'h50000000 + 32'(i));
        check("rbw_index3", 32'(wr_index), 32'h3);
        rd_addr = 4'd3;
        result = 32'h12345678;
        storeData = 1'b1;
        tick(1);
        tick(1);
        check("rbw_old", rd_data, 32'h3f800003);
        storeData = 1'b0;
        tick(1);
        check("rbw_new", rd_data, 32'h12345678);
        tick(2);

`ifdef RESULT_CHECK_EN
        do_reset();
        pulse_store(32'h40224dd3);
        check("mm_match_cnt", 32'(mismatch_cnt), 32'h0);
        check("mm_match_flag", 32'(mismatch),    32'h0);
        pulse_store(32'h00000000);
        check("mm_cnt",   32'(mismatch_cnt), 32'h1);
        check("mm_flag",  32'(mismatch),     32'h1);
        check("mm_index", 32'(wr_index),     32'h2);
        tick(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
